inst_code_writer: RTL and testbench
===================================

// Module: inst_code_writer
// PURPOSE
//  Write side of the instruction memory that the fetch/decode stage reads.
//  Takes MIPS R-format fields (op_code, rs, rt, rd, shamt, funct) over a valid/ready handshake.
//  Packs each set into a 32-bit Inst_code and writes it to sequential instruction-memory addresses.
//  Used to load programs into the instruction RAM before the fetch stage is released.
// PARAMETERS
//  ADDR_W      6    instruction-memory word-address width
//  DEPTH       64   number of words writable per load session (<= 2**ADDR_W)
//  START_ADDR  0    first word address of every load session
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        synchronous reset, active-low (0 = reset, sampled on clk rising edge)
//  load_start  in   1        1-cycle pulse: open a load session
//  load_end    in   1        1-cycle pulse: close the session
//  in_valid    in   1        field set on inputs is valid
//  in_ready    out  1        block can accept a field set this cycle
//  op_code     in   6        Inst_code[31:26]
//  rs_addr     in   5        Inst_code[25:21]
//  rt_addr     in   5        Inst_code[20:16]
//  rd_addr     in   5        Inst_code[15:11]
//  shamt       in   5        Inst_code[10:6]
//  funct       in   6        Inst_code[5:0]
//  mem_we      out  1        instruction-memory write strobe
//  mem_addr    out  ADDR_W   instruction-memory word address
//  mem_wdata   out  32       packed Inst_code
//  mem_rdata   in   32       combinational read data at mem_addr (used only with READBACK_EN)
//  word_count  out  ADDR_W+1 words written in the current session
//  full        out  1        DEPTH words written
//  done        out  1        1-cycle pulse when the session closes
//  err         out  1        sticky read-back mismatch flag
//  LED         out  8        {busy, full, word_count[5:0]}; busy = state != IDLE
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE; in_ready, mem_we, full, done and err = 0.
//   mem_addr=START_ADDR; mem_wdata=0; word_count=0.
//   Reset during WRITE/VERIFY aborts the write; mem_we is 0 from the next cycle.
//  States: IDLE, ACCEPT, WRITE, VERIFY (READBACK_EN only), FULL.
//  IDLE:   load_start -> ACCEPT; ptr=START_ADDR, word_count=0, err=0. All other inputs ignored.
//  ACCEPT: in_ready=1. in_valid&in_ready -> latch
//           mem_wdata={op_code,rs_addr,rt_addr,rd_addr,shamt,funct}, then go to WRITE.
//          load_end with no handshake -> IDLE, done=1 for 1 cycle.
//  WRITE:  exactly 1 cycle; mem_we=1, mem_addr=ptr, in_ready=0.
//          Then ptr+1 and word_count+1.
//          Next state: VERIFY if enabled, else FULL if word_count==DEPTH, else ACCEPT.
//  Latency: handshake at edge N -> mem_we high in cycle N+1.
//   Max throughput is 1 word per 2 cycles (3 with READBACK_EN).
//  load_end together with a handshake in ACCEPT, or arriving during WRITE/VERIFY:
//   the word is still written, a pending-end flag is set, and the block returns to IDLE
//   with done=1 instead of going back to ACCEPT.
//  FULL: full=1, in_ready=0, handshakes refused.
//   load_end -> IDLE with a done pulse, full cleared.
//   load_start -> new session directly (ptr=START_ADDR, count=0).
//  load_start in ACCEPT/WRITE/VERIFY is ignored.
//  ptr wraps modulo 2**ADDR_W; with DEPTH <= 2**ADDR_W, wrap occurs only if START_ADDR+DEPTH exceeds 2**ADDR_W.
//  mem_addr and mem_wdata hold their last values when mem_we=0.
// CONFIGURATION
//  READBACK_EN defined: after WRITE, 1 cycle in VERIFY with mem_we=0 and mem_addr = the just-written address.
//   If mem_rdata != mem_wdata, err is set (sticky until the next load_start or reset).
//   Session continues either way.
//  READBACK_EN undefined: no VERIFY state; err is tied 0; mem_rdata is unused.
// TESTING
//  1 rst=0 for 2 clk, then release -> all outputs at reset values, LED=8'h00, in_ready=0.
//  2 load_start, then 1 word op=0,rs=1,rt=2,rd=3,shamt=0,funct=6'h20
//     -> mem_we pulse at addr 0, mem_wdata=32'h00221820, word_count=1.
//  3 back-to-back in_valid for 3 words -> in_ready drops during each WRITE;
//     writes land at addr 0,1,2; load_end -> done pulse, LED=8'h03.
//  4 DEPTH=4, 5 words offered -> 4 written; full=1, in_ready=0; 5th word never written;
//     load_start restarts at addr 0.
//  5 load_end in the same cycle as a handshake -> word written, then done; state IDLE.
//  6 (READBACK_EN) memory model corrupts word 1 -> err=1 after its VERIFY cycle;
//     err stays set through load_end; next load_start clears it.

Source files
------------

// File: rtl/inst_code_writer_if.sv
// Field-set handshake and instruction-memory write bus of inst_code_writer.
// slave = the writer block; master = field source plus instruction RAM.
interface inst_code_writer_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        op_code;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [4:0]        rd_addr;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output in_valid, op_code, rs_addr, rt_addr, rd_addr, shamt, funct, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op_code, rs_addr, rt_addr, rd_addr, shamt, funct, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_code_writer.sv
// Packs MIPS R-format field sets into 32-bit Inst_codes and writes them to sequential
// instruction-memory words. Define READBACK_EN to add a read-back VERIFY cycle per word.
module inst_code_writer #(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_end,
  inst_code_writer_if.slave bus,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              done,
  output logic              err,
  output logic [7:0]        LED
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    VERIFY,
    FULL
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] START_W = ADDR_W'(START_ADDR);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              end_pend;
  logic              end_pend_nxt;
  logic              open_session;
  logic              handshake;
  logic              word_done;
  logic              done_nxt;
  logic [ADDR_W:0]   count_inc;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    open_session = 1'b0;
    handshake    = 1'b0;
    word_done    = 1'b0;
    done_nxt     = 1'b0;
    end_pend_nxt = end_pend;
    count_inc    = word_count + 1'b1;
    case (state)
      IDLE: begin
        if (load_start) begin
          open_session = 1'b1;
          end_pend_nxt = 1'b0;
          state_nxt    = ACCEPT;
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          handshake    = 1'b1;
          end_pend_nxt = load_end;
          state_nxt    = WRITE;
        end else if (load_end) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        word_done = 1'b1;
`ifdef READBACK_EN
        if (load_end) end_pend_nxt = 1'b1;
        state_nxt = VERIFY;
`else
        if (end_pend || load_end) begin
          end_pend_nxt = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end else if (count_inc == DEPTH_W) begin
          state_nxt = FULL;
        end else begin
          state_nxt = ACCEPT;
        end
`endif
      end
`ifdef READBACK_EN
      // word_count already includes the word just written
      VERIFY: begin
        if (end_pend || load_end) begin
          end_pend_nxt = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end else if (word_count == DEPTH_W) begin
          state_nxt = FULL;
        end else begin
          state_nxt = ACCEPT;
        end
      end
`endif
      FULL: begin
        if (load_end) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (load_start) begin
          open_session = 1'b1;
          end_pend_nxt = 1'b0;
          state_nxt    = ACCEPT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr/mem_wdata are captured at the handshake so they hold through WRITE and VERIFY
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr           <= START_W;
      word_count    <= '0;
      end_pend      <= 1'b0;
      done          <= 1'b0;
      bus.mem_addr  <= START_W;
      bus.mem_wdata <= '0;
    end else begin
      done     <= done_nxt;
      end_pend <= end_pend_nxt;
      if (open_session) begin
        ptr        <= START_W;
        word_count <= '0;
      end
      if (handshake) begin
        bus.mem_wdata <= {bus.op_code, bus.rs_addr, bus.rt_addr,
                          bus.rd_addr, bus.shamt, bus.funct};
        bus.mem_addr  <= ptr;
      end
      if (word_done) begin
        ptr        <= ptr + 1'b1;
        word_count <= count_inc;
      end
    end
  end

`ifdef READBACK_EN
  always_ff @(posedge clk) begin
    if (!rst)                                                  err <= 1'b0;
    else if (open_session)                                     err <= 1'b0;
    else if (state == VERIFY && bus.mem_rdata != bus.mem_wdata) err <= 1'b1;
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;
  assign err          = 1'b0;
`endif

  assign bus.in_ready = (state == ACCEPT);
  assign bus.mem_we   = (state == WRITE);
  assign full         = (state == FULL);
  assign LED          = {state != IDLE, full, word_count[5:0]};

endmodule

// File: tb/tb_inst_code_writer.sv
// Randomized self-checking bench for inst_code_writer against a word-level model:
// expected writes are queued at handshake time and matched against every mem_we.
module tb_inst_code_writer;
  localparam int ADDR_W     = 6;
  localparam int DEPTH      = 4;
  localparam int START_ADDR = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic              load_end = 1'b0;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              done;
  logic              err;
  logic [7:0]        LED;

  inst_code_writer_if #(.ADDR_W(ADDR_W)) bus ();

  inst_code_writer #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .START_ADDR(START_ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .load_end  (load_end),
    .bus       (bus),
    .word_count(word_count),
    .full      (full),
    .done      (done),
    .err       (err),
    .LED       (LED)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction RAM model with an optional single corrupted read address
  logic [31:0]       mem [64];
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;

  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr] ^
                         ((corrupt_en && bus.mem_addr == corrupt_addr) ? 32'h1 : 32'h0);

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  m_count  = 0;
  bit  m_active = 0;
  bit  m_err    = 0;

  function automatic logic [31:0] pack(input int unsigned op, rs, rt, rd, sh, fn);
    return 32'(op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) +
               rd * (1 << 11) + sh * (1 << 6) + fn);
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (rst && bus.mem_we) begin
      check_eq("in_ready during write", 64'(bus.in_ready), 64'(0));
      check_eq("write expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("write addr", 64'(bus.mem_addr), 64'(e.addr));
        check_eq("write data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    check_eq("done pulse", 64'(seen), 64'(1));
    if (seen) begin
      check_eq("LED after end", 64'(LED), 64'({2'b00, 6'(m_count)}));
      check_eq("word_count after end", 64'(word_count), 64'(m_count));
      check_eq("full after end", 64'(full), 64'(0));
      check_eq("err after end", 64'(err), 64'(m_err));
      @(negedge clk);
      check_eq("done width", 64'(done), 64'(0));
    end
  endtask

  task automatic start_session();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    m_active = 1;
    m_count  = 0;
    m_err    = 0;
    check_eq("count at start", 64'(word_count), 64'(0));
    check_eq("in_ready at start", 64'(bus.in_ready), 64'(1));
    check_eq("err at start", 64'(err), 64'(0));
  endtask

  task automatic end_session();
    load_end = 1'b1;
    @(negedge clk);
    load_end = 1'b0;
    m_active = 0;
    wait_done();
  endtask

  task automatic check_full();
    bit seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (full) seen = 1;
    end
    check_eq("full reached", 64'(seen), 64'(1));
    check_eq("in_ready when full", 64'(bus.in_ready), 64'(0));
    check_eq("LED when full", 64'(LED), 64'({2'b11, 6'(m_count)}));
  endtask

  // Returns at the falling edge of the WRITE cycle when the word is taken
  task automatic send_word(input int unsigned op, rs, rt, rd, sh, fn, input bit with_end);
    bit                accepted = 0;
    bit                exp_acc;
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
    w       = pack(op, rs, rt, rd, sh, fn);
    a       = ADDR_W'(START_ADDR + m_count);
    exp_acc = m_active && (m_count < DEPTH);
    bus.in_valid = 1'b1;
    bus.op_code  = 6'(op);
    bus.rs_addr  = 5'(rs);
    bus.rt_addr  = 5'(rt);
    bus.rd_addr  = 5'(rd);
    bus.shamt    = 5'(sh);
    bus.funct    = 6'(fn);
    for (int i = 0; i < 8 && !accepted; i++) begin
      if (bus.in_ready) begin
        accepted = 1;
        load_end = with_end;
        if (exp_acc) exp_q.push_back('{addr: a, data: w});
      end
      @(negedge clk);
      load_end = 1'b0;
    end
    bus.in_valid = 1'b0;
    check_eq("handshake accepted", 64'(accepted), 64'(exp_acc));
    if (accepted && exp_acc) begin
      check_eq("write latency", 64'(bus.mem_we), 64'(1));
      m_count++;
`ifdef READBACK_EN
      if (corrupt_en && a == corrupt_addr) m_err = 1;
`endif
      if (with_end) begin
        m_active = 0;
        wait_done();
      end
    end
  endtask

  task automatic send_rand(input bit with_end);
    send_word($urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63), with_end);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit end_with;
    bus.in_valid = 1'b0;
    bus.op_code  = '0;
    bus.rs_addr  = '0;
    bus.rt_addr  = '0;
    bus.rd_addr  = '0;
    bus.shamt    = '0;
    bus.funct    = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("reset in_ready", 64'(bus.in_ready), 64'(0));
    check_eq("reset mem_we", 64'(bus.mem_we), 64'(0));
    check_eq("reset full", 64'(full), 64'(0));
    check_eq("reset done", 64'(done), 64'(0));
    check_eq("reset err", 64'(err), 64'(0));
    check_eq("reset mem_addr", 64'(bus.mem_addr), 64'(START_ADDR));
    check_eq("reset mem_wdata", 64'(bus.mem_wdata), 64'(0));
    check_eq("reset word_count", 64'(word_count), 64'(0));
    check_eq("reset LED", 64'(LED), 64'(8'h00));

    // single known word
    start_session();
    send_word(0, 1, 2, 3, 0, 'h20, 0);
    check_eq("known word data", 64'(bus.mem_wdata), 64'(32'h0022_1820));
    check_eq("known word addr", 64'(bus.mem_addr), 64'(0));
    @(negedge clk);
    check_eq("known word count", 64'(word_count), 64'(1));
    end_session();

    // three back-to-back words then a separate end
    start_session();
    for (int k = 0; k < 3; k++) send_rand(0);
    end_session();
    check_eq("LED after 3 words", 64'(LED), 64'(8'h03));

    // overfill: last word refused, restart from FULL
    start_session();
    for (int k = 0; k < DEPTH + 1; k++) begin
      send_rand(0);
      if (m_count == DEPTH) check_full();
    end
    start_session();
    send_rand(0);
    check_eq("restart addr", 64'(bus.mem_addr), 64'(START_ADDR));
    end_session();

    // end in the same cycle as the handshake
    start_session();
    send_rand(1);
    check_eq("idle after end+handshake in_ready", 64'(bus.in_ready), 64'(0));
    check_eq("idle after end+handshake busy", 64'(LED[7]), 64'(0));

`ifdef READBACK_EN
    // corrupted read-back of word 1
    corrupt_en   = 1'b1;
    corrupt_addr = ADDR_W'(START_ADDR + 1);
    start_session();
    send_rand(0);
    send_rand(0);
    repeat (2) @(negedge clk);
    check_eq("err after bad verify", 64'(err), 64'(1));
    send_rand(0);
    end_session();
    corrupt_en = 1'b0;
    start_session();
    end_session();
`endif

    // reset while writing
    start_session();
    send_rand(0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort mem_we", 64'(bus.mem_we), 64'(0));
    check_eq("abort in_ready", 64'(bus.in_ready), 64'(0));
    check_eq("abort word_count", 64'(word_count), 64'(0));
    check_eq("abort mem_addr", 64'(bus.mem_addr), 64'(START_ADDR));
    rst = 1'b1;
    exp_q.delete();
    m_active = 0;
    m_count  = 0;
    m_err    = 0;
    @(negedge clk);

    // randomized sessions
    repeat (25) begin
      corrupt_en   = 1'($urandom_range(0, 1));
      corrupt_addr = ADDR_W'($urandom_range(START_ADDR, START_ADDR + DEPTH - 1));
      start_session();
      n        = $urandom_range(1, DEPTH + 1);
      end_with = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_rand(end_with && (k == n - 1));
        if (!m_active) break;
        if (m_count == DEPTH) check_full();
      end
      if (m_active) end_session();
    end
    corrupt_en = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("no leftover writes", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
